hsv_threshold_bbox: RTL and testbench
=====================================

HSV_THRESHOLD_BBOX -- requirements
Module: hsv_threshold_bbox

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of the x/y coordinate counters and box outputs.
REQ-002 SHALL have parameter PIX_W, default 24, width of the foreground pixel counter.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  pixel clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- hsv_hs  in  1  horizontal sync from the HSV stage, active-high.
- hsv_vs  in  1  vertical sync from the HSV stage, active-high.
- hsv_de  in  1  data enable, active-high.
- hsv  in  24  {hue[23:16], saturation[15:8], value[7:0]}; hue ignored.
- s_min  in  8  saturation threshold.
- v_min  in  8  value threshold.
- mask_hs  out  1  hsv_hs delayed 1 cycle.
- mask_vs  out  1  hsv_vs delayed 1 cycle.
- mask_de  out  1  hsv_de delayed 1 cycle.
- mask  out  24  24'hFFFFFF for a foreground pixel, else 24'h000000.
- box_valid  out  1  high while box_* describe a frame with at least one foreground pixel.
- box_update  out  1  one-cycle pulse when frame results are published.
- box_x_min, box_x_max, box_y_min, box_y_max  out  CNT_W each  bounding box of the last completed frame.
- pix_count  out  PIX_W  foreground pixel count of the last completed frame.

Function
REQ-005 SHALL treat a pixel as foreground when hsv_de=1, saturation >= s_min_r and value >= v_min_r, using unsigned 8-bit compares.
REQ-006 SHALL register mask and the mask_hs/vs/de delays with exactly 1 cycle latency; mask SHALL be 0 whenever the delayed de is 0.
REQ-007 SHALL capture s_min/v_min into s_min_r/v_min_r only on a vs rising edge (hsv_vs=1, previous vs=0), so threshold changes mid-frame take effect next frame.
REQ-008 SHALL keep x counter = index of the current pixel within its line: 0 on the first de cycle of a line, +1 per de cycle, reset to 0 on de falling, saturating at 2^CNT_W-1.
REQ-009 SHALL keep y counter = line index: +1 on each de falling edge, reset to 0 on vs rising edge, saturating at 2^CNT_W-1.
REQ-010 SHALL, per foreground pixel, update accumulators: acc_x_min/x_max/y_min/y_max via min/max, and acc_count +1 saturating at 2^PIX_W-1.
REQ-011 SHALL initialise the accumulators at frame start to x_min=y_min=all-ones, x_max=y_max=0, count=0.
REQ-012 SHALL implement a 2-state FSM: WAIT_FRAME (after reset, no accumulation) -> ACCUM on the first vs rising edge; ACCUM -> ACCUM on each later vs rising edge.
REQ-013 SHALL, on a vs rising edge in ACCUM, publish accumulators to box_*/pix_count, set box_valid = (acc_count != 0), and pulse box_update for exactly 1 cycle in the same clock edge; the first vs rising edge from WAIT_FRAME SHALL NOT publish.
REQ-014 SHALL output box_* = 0 when publishing a frame with acc_count = 0.
REQ-015 SHALL, when a vs rising edge coincides with a foreground de pixel, exclude that pixel from the published frame and count it as pixel (x, y=0) of the new frame.
REQ-016 SHALL hold published outputs stable between box_update pulses.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously clear mask, mask_hs/vs/de, box_valid, box_update, box_*, pix_count to 0, all counters and accumulators to their frame-start values, thresholds to 0, vs/de edge history to 0, and the FSM to WAIT_FRAME.
REQ-018 SHALL discard any partial frame when reset asserts mid-frame; no box_update follows until two vs rising edges after release.

Verification
REQ-019 Thresholds s_min=80, v_min=100; pixel (S=80, V=100) -> mask=FFFFFF one cycle later; (S=79, V=200) -> mask=0.
REQ-020 4x4 frame, foreground at (1,2) and (3,0), then vs rise -> box_update pulse, box_x_min=1, x_max=3, y_min=0, y_max=2, pix_count=2, box_valid=1.
REQ-021 Frame with no foreground -> box_update pulse, box_valid=0, box_* = 0, pix_count=0.
REQ-022 First vs rise after reset -> no box_update; the second vs rise -> box_update.
REQ-023 s_min changed 0->255 mid-frame -> current frame's mask unchanged; next frame uses 255.
REQ-024 rst_n low mid-frame with foreground present -> all outputs 0 immediately; first post-reset vs rise yields no box_update.

Source files
------------

// File: rtl/hsv_threshold_bbox.sv
// HSV saturation/value threshold with per-frame foreground bounding box.
// Produces a 1-cycle-latency binary mask stream and, on each vsync rising
// edge, publishes the bounding box and pixel count of the frame just ended.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// WAIT_FRAME | out of reset, no frame start seen yet; nothing accumulated
// ACCUM      | accumulating the current frame; next vs rise publishes it
module hsv_threshold_bbox #(
  parameter int CNT_W = 12,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsv_hs,
  input  logic             hsv_vs,
  input  logic             hsv_de,
  input  logic [23:0]      hsv,
  input  logic [7:0]       s_min,
  input  logic [7:0]       v_min,
  output logic             mask_hs,
  output logic             mask_vs,
  output logic             mask_de,
  output logic [23:0]      mask,
  output logic             box_valid,
  output logic             box_update,
  output logic [CNT_W-1:0] box_x_min,
  output logic [CNT_W-1:0] box_x_max,
  output logic [CNT_W-1:0] box_y_min,
  output logic [CNT_W-1:0] box_y_max,
  output logic [PIX_W-1:0] pix_count
);

  typedef enum logic {WAIT_FRAME = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  state_t           state_q, state_d;
  logic             vs_q, de_q;
  logic [7:0]       s_min_q, v_min_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [CNT_W-1:0] acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [PIX_W-1:0] acc_count_q, acc_count_d;
  logic             hs_dly_q, vs_dly_q, de_dly_q, fg_dly_q;
  logic             box_valid_q, box_update_q;
  logic [CNT_W-1:0] box_x_min_q, box_x_max_q, box_y_min_q, box_y_max_q;
  logic [PIX_W-1:0] pix_count_q;

  logic             vs_rise, de_fall, fg, accum_en, publish;
  logic [CNT_W-1:0] pix_y;

  assign vs_rise  = hsv_vs & ~vs_q;
  assign de_fall  = ~hsv_de & de_q;
  assign fg       = hsv_de && (hsv[15:8] >= s_min_q) && (hsv[7:0] >= v_min_q);
  // A pixel coincident with the frame-start edge is the first line of the new frame.
  assign pix_y    = vs_rise ? '0 : y_q;
  assign accum_en = fg && (vs_rise || (state_q == ACCUM));
  assign publish  = vs_rise && (state_q == ACCUM);

  // Next-state: leave WAIT_FRAME on the first frame start, then stay in ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (vs_rise) state_d = ACCUM;
      ACCUM:      state_d = ACCUM;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // Pixel/line position counters, both saturating.
  always_comb begin
    x_d = '0;
    if (hsv_de) x_d = (x_q == CNT_MAX) ? x_q : x_q + CNT_W'(1);
    y_d = y_q;
    if (vs_rise)                        y_d = '0;
    else if (de_fall && y_q != CNT_MAX) y_d = y_q + CNT_W'(1);
  end

  // Accumulators: re-seed at frame start, then fold in each foreground pixel.
  always_comb begin
    acc_x_min_d = acc_x_min_q;
    acc_x_max_d = acc_x_max_q;
    acc_y_min_d = acc_y_min_q;
    acc_y_max_d = acc_y_max_q;
    acc_count_d = acc_count_q;
    if (vs_rise) begin
      acc_x_min_d = CNT_MAX;
      acc_x_max_d = '0;
      acc_y_min_d = CNT_MAX;
      acc_y_max_d = '0;
      acc_count_d = '0;
    end
    if (accum_en) begin
      if (x_q < acc_x_min_d)   acc_x_min_d = x_q;
      if (x_q > acc_x_max_d)   acc_x_max_d = x_q;
      if (pix_y < acc_y_min_d) acc_y_min_d = pix_y;
      if (pix_y > acc_y_max_d) acc_y_max_d = pix_y;
      if (acc_count_d != PIX_MAX) acc_count_d = acc_count_d + PIX_W'(1);
    end
  end

  // State, counters, thresholds, mask pipeline and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_FRAME;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      s_min_q      <= '0;
      v_min_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      acc_x_min_q  <= CNT_MAX;
      acc_x_max_q  <= '0;
      acc_y_min_q  <= CNT_MAX;
      acc_y_max_q  <= '0;
      acc_count_q  <= '0;
      hs_dly_q     <= 1'b0;
      vs_dly_q     <= 1'b0;
      de_dly_q     <= 1'b0;
      fg_dly_q     <= 1'b0;
      box_valid_q  <= 1'b0;
      box_update_q <= 1'b0;
      box_x_min_q  <= '0;
      box_x_max_q  <= '0;
      box_y_min_q  <= '0;
      box_y_max_q  <= '0;
      pix_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= hsv_vs;
      de_q         <= hsv_de;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_x_min_q  <= acc_x_min_d;
      acc_x_max_q  <= acc_x_max_d;
      acc_y_min_q  <= acc_y_min_d;
      acc_y_max_q  <= acc_y_max_d;
      acc_count_q  <= acc_count_d;
      hs_dly_q     <= hsv_hs;
      vs_dly_q     <= hsv_vs;
      de_dly_q     <= hsv_de;
      fg_dly_q     <= fg;
      box_update_q <= publish;
      if (vs_rise) begin
        s_min_q <= s_min;
        v_min_q <= v_min;
      end
      if (publish) begin
        box_valid_q <= (acc_count_q != '0);
        pix_count_q <= acc_count_q;
        if (acc_count_q != '0) begin
          box_x_min_q <= acc_x_min_q;
          box_x_max_q <= acc_x_max_q;
          box_y_min_q <= acc_y_min_q;
          box_y_max_q <= acc_y_max_q;
        end else begin
          box_x_min_q <= '0;
          box_x_max_q <= '0;
          box_y_min_q <= '0;
          box_y_max_q <= '0;
        end
      end
    end
  end

  assign mask_hs    = hs_dly_q;
  assign mask_vs    = vs_dly_q;
  assign mask_de    = de_dly_q;
  assign mask       = {24{fg_dly_q}};
  assign box_valid  = box_valid_q;
  assign box_update = box_update_q;
  assign box_x_min  = box_x_min_q;
  assign box_x_max  = box_x_max_q;
  assign box_y_min  = box_y_min_q;
  assign box_y_max  = box_y_max_q;
  assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_hsv_threshold_bbox.sv
// Scoreboard bench for hsv_threshold_bbox. The driver builds frames from
// loop indices, a frame-level reference model keeps the list of foreground
// pixels per frame, and a monitor compares every output cycle.
module tb_hsv_threshold_bbox;
  localparam int CW   = 3;
  localparam int PW   = 4;
  localparam int CMAX = 7;
  localparam int PMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hsv_hs = 1'b0, hsv_vs = 1'b0, hsv_de = 1'b0;
  logic [23:0]   hsv = '0;
  logic [7:0]    s_min = '0, v_min = '0;
  logic          mask_hs, mask_vs, mask_de;
  logic [23:0]   mask;
  logic          box_valid, box_update;
  logic [CW-1:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [PW-1:0] pix_count;

  always #5 clk = ~clk;

  hsv_threshold_bbox #(.CNT_W(CW), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .hsv_hs(hsv_hs), .hsv_vs(hsv_vs), .hsv_de(hsv_de),
    .hsv(hsv), .s_min(s_min), .v_min(v_min),
    .mask_hs(mask_hs), .mask_vs(mask_vs), .mask_de(mask_de), .mask(mask),
    .box_valid(box_valid), .box_update(box_update),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max), .pix_count(pix_count)
  );

  typedef struct {
    logic        hs, vs, de;
    logic [23:0] mask;
    logic        bv, bu;
    int          xmn, xmx, ymn, ymx, cnt;
  } exp_t;

  typedef struct { int x; int y; } pt_t;

  exp_t expq[$];
  pt_t  fl[$];
  exp_t mon_e;
  int   n_chk = 0, n_err = 0;

  // reference model state
  bit   m_prev_vs, m_started, m_bv, rnd_thr;
  int   m_ts, m_tv, m_xmn, m_xmx, m_ymn, m_ymx, m_cnt;

  function automatic int sat(int a, int m);
    return (a > m) ? m : a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_vs = 0; m_started = 0; m_ts = 0; m_tv = 0;
    m_bv = 0; m_xmn = 0; m_xmx = 0; m_ymn = 0; m_ymx = 0; m_cnt = 0;
    fl.delete();
  endtask

  // One pixel-clock cycle of stimulus plus the model's expected response.
  task automatic cyc(bit rst_b, bit hs, bit vs, bit de, logic [7:0] s, logic [7:0] v, int i, int j);
    exp_t e;
    bit   rise, fgp;
    int   n;
    @(negedge clk);
    if (rnd_thr && $urandom_range(0, 15) == 0) begin
      s_min = 8'($urandom_range(0, 255));
      v_min = 8'($urandom_range(0, 255));
    end
    rst_n  = rst_b;
    hsv_hs = hs; hsv_vs = vs; hsv_de = de;
    hsv    = {8'($urandom_range(0, 255)), s, v};
    e = '{default: 0};
    if (!rst_b) begin
      #1;
      chk("rst_mask", 32'(mask), 0);
      chk("rst_sync", {29'd0, mask_hs, mask_vs, mask_de}, 0);
      chk("rst_flags", {30'd0, box_valid, box_update}, 0);
      chk("rst_box", {20'd0, box_x_min, box_x_max, box_y_min, box_y_max}, 0);
      chk("rst_count", 32'(pix_count), 0);
      model_reset();
    end else begin
      rise   = vs && !m_prev_vs;
      fgp    = de && (int'(s) >= m_ts) && (int'(v) >= m_tv);
      e.hs   = hs; e.vs = vs; e.de = de;
      e.mask = fgp ? 24'hFFFFFF : 24'h0;
      e.bu   = 0;
      if (rise) begin
        if (m_started) begin
          n = fl.size();
          m_cnt = sat(n, PMAX);
          m_bv  = (n != 0);
          if (n == 0) begin
            m_xmn = 0; m_xmx = 0; m_ymn = 0; m_ymx = 0;
          end else begin
            m_xmn = CMAX; m_xmx = 0; m_ymn = CMAX; m_ymx = 0;
            foreach (fl[k]) begin
              if (fl[k].x < m_xmn) m_xmn = fl[k].x;
              if (fl[k].x > m_xmx) m_xmx = fl[k].x;
              if (fl[k].y < m_ymn) m_ymn = fl[k].y;
              if (fl[k].y > m_ymx) m_ymx = fl[k].y;
            end
          end
          e.bu = 1;
        end
        m_started = 1;
        fl.delete();
        m_ts = int'(s_min);
        m_tv = int'(v_min);
        if (fgp) fl.push_back('{sat(i, CMAX), 0});
      end else if (fgp && m_started) begin
        fl.push_back('{sat(i, CMAX), sat(j, CMAX)});
      end
      m_prev_vs = vs;
      e.bv = m_bv; e.xmn = m_xmn; e.xmx = m_xmx;
      e.ymn = m_ymn; e.ymx = m_ymx; e.cnt = m_cnt;
    end
    expq.push_back(e);
  endtask

  // mode 0: random pixels; 1: foreground only at (1,2),(3,0);
  // 2: all S=V=200 with s_min raised to 255 during line 1; 3: no foreground.
  task automatic frame(int w, int h, bit coinc, int mode);
    logic [7:0] s, v;
    bit         vv, pat;
    if (!coinc) begin
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int j = 0; j < h; j++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < w; i++) begin
        vv = coinc && (j == 0) && (i < 2);
        case (mode)
          1: begin
            pat = ((i == 1) && (j == 2)) || ((i == 3) && (j == 0));
            s = pat ? 8'd80 : 8'd79;
            v = pat ? 8'd100 : 8'd200;
          end
          2: begin
            if (j == 1 && i == 0) s_min = 8'd255;
            s = 8'd200; v = 8'd200;
          end
          3: begin s = 8'd79; v = 8'd200; end
          default: begin
            s = 8'($urandom_range(0, 255));
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin s = s_min; v = v_min; end
          end
        endcase
        cyc(1, 0, vv, 1, s, v, i, j);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // monitor: pops one expected record per output cycle
  always begin
    @(posedge clk);
    #1;
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      chk("mask_hs", 32'(mask_hs), 32'(mon_e.hs));
      chk("mask_vs", 32'(mask_vs), 32'(mon_e.vs));
      chk("mask_de", 32'(mask_de), 32'(mon_e.de));
      chk("mask", 32'(mask), 32'(mon_e.mask));
      chk("box_update", 32'(box_update), 32'(mon_e.bu));
      chk("box_valid", 32'(box_valid), 32'(mon_e.bv));
      chk("box_x_min", 32'(box_x_min), mon_e.xmn);
      chk("box_x_max", 32'(box_x_max), mon_e.xmx);
      chk("box_y_min", 32'(box_y_min), mon_e.ymn);
      chk("box_y_max", 32'(box_y_max), mon_e.ymx);
      chk("pix_count", 32'(pix_count), mon_e.cnt);
    end
  end

  initial begin
    model_reset();
    rnd_thr = 0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // directed: threshold edges, 4x4 box, empty frame, mid-frame threshold change
    s_min = 8'd80; v_min = 8'd100;
    frame(4, 4, 0, 1);
    frame(4, 4, 0, 1);
    frame(4, 4, 0, 3);
    frame(4, 4, 0, 2);
    frame(4, 4, 0, 1);
    s_min = 8'd80;
    frame(3, 3, 1, 1);
    frame(4, 4, 1, 0);

    // reset in the middle of a line with foreground pixels
    cyc(1, 0, 0, 1, 8'd200, 8'd200, 0, 0);
    cyc(1, 0, 0, 1, 8'd200, 8'd200, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    frame(4, 3, 0, 1);
    frame(4, 3, 0, 0);

    // randomized frames, including saturation of x, y and count
    for (int k = 0; k < 25; k++) begin
      if (k % 6 == 0) begin
        rnd_thr = 0; s_min = 8'd0; v_min = 8'd0;
      end else begin
        rnd_thr = 1;
      end
      frame($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(0, 3) == 0, 0);
    end
    rnd_thr = 0;
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
